// File: rtl/alu_operand_stage_if.sv
// Bundle between the decode/forwarding sources and the ID/EX operand stage.
// The stage itself connects through the slave modport; the driving side uses master.
interface alu_operand_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
);
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1_addr;
    logic [REGW-1:0] id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_a_sel;
    logic            id_b_sel;
    logic [3:0]      id_alu_control;
    logic [REGW-1:0] id_rd_addr;
    logic            id_reg_write;
    logic            id_mem_read;
    logic [XLEN-1:0] alu_result;
    logic [REGW-1:0] mem_rd_addr;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_fwd_data;
    logic            ex_ready;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_in_a;
    logic [XLEN-1:0] ex_in_b;
    logic [3:0]      ex_alu_control;
    logic [REGW-1:0] ex_rd_addr;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic [31:0]     bubble_count;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_a_sel, id_b_sel, id_alu_control, id_rd_addr, id_reg_write,
               id_mem_read, alu_result, mem_rd_addr, mem_reg_write, mem_fwd_data,
               ex_ready, flush,
        input  id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control, ex_rd_addr,
               ex_reg_write, ex_mem_read, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_a_sel, id_b_sel, id_alu_control, id_rd_addr, id_reg_write,
               id_mem_read, alu_result, mem_rd_addr, mem_reg_write, mem_fwd_data,
               ex_ready, flush,
        output id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control, ex_rd_addr,
               ex_reg_write, ex_mem_read, bubble_count
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: operand select with EX/MEM forwarding at capture,
// load-use bubble insertion, stall/flush handling and a saturating bubble counter.
module alu_operand_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REGW     = 5,
    parameter int unsigned BUBBLE_W = 32
) (
    input logic                clk,
    input logic                rst,
    alu_operand_stage_if.slave bus
);
    logic                valid_q, valid_d;
    logic [XLEN-1:0]     in_a_q, in_a_d;
    logic [XLEN-1:0]     in_b_q, in_b_d;
    logic [3:0]          ctl_q, ctl_d;
    logic [REGW-1:0]     rd_q, rd_d;
    logic                rw_q, rw_d;
    logic                mr_q, mr_d;
    logic [BUBBLE_W-1:0] bub_q, bub_d;

    logic            advance;
    logic            hazard;
    logic            a_hit, b_hit;
    logic            ex_fwd_ok, mem_fwd_ok;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] op_a, op_b;

    always_comb begin
        advance = bus.ex_ready | ~valid_q;
        a_hit   = ~bus.id_a_sel & (bus.id_rs1_addr == rd_q);
        b_hit   = ~bus.id_b_sel & (bus.id_rs2_addr == rd_q);
        hazard  = bus.id_valid & valid_q & mr_q & rw_q & (rd_q != '0) & (a_hit | b_hit);
        bus.id_ready = ~rst & advance & ~hazard & ~bus.flush;
    end

    // A held load never forwards from alu_result; its data arrives later via MEM.
    always_comb begin
        ex_fwd_ok  = valid_q & rw_q & ~mr_q & (rd_q != '0);
        mem_fwd_ok = bus.mem_reg_write & (bus.mem_rd_addr != '0);

        if (ex_fwd_ok && (bus.id_rs1_addr == rd_q)) begin
            rs1_val = bus.alu_result;
        end else if (mem_fwd_ok && (bus.id_rs1_addr == bus.mem_rd_addr)) begin
            rs1_val = bus.mem_fwd_data;
        end else begin
            rs1_val = bus.id_rs1_data;
        end

        if (ex_fwd_ok && (bus.id_rs2_addr == rd_q)) begin
            rs2_val = bus.alu_result;
        end else if (mem_fwd_ok && (bus.id_rs2_addr == bus.mem_rd_addr)) begin
            rs2_val = bus.mem_fwd_data;
        end else begin
            rs2_val = bus.id_rs2_data;
        end

        op_a = bus.id_a_sel ? bus.id_pc  : rs1_val;
        op_b = bus.id_b_sel ? bus.id_imm : rs2_val;
    end

    always_comb begin
        valid_d = valid_q;
        in_a_d  = in_a_q;
        in_b_d  = in_b_q;
        ctl_d   = ctl_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        bub_d   = bub_q;

        if (bus.flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
        end else if (!advance) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            bub_d   = (&bub_q) ? bub_q : bub_q + BUBBLE_W'(1);
        end else begin
            valid_d = bus.id_valid;
            in_a_d  = op_a;
            in_b_d  = op_b;
            ctl_d   = bus.id_alu_control;
            rd_d    = bus.id_rd_addr;
            rw_d    = bus.id_valid & bus.id_reg_write;
            mr_d    = bus.id_valid & bus.id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            in_a_q  <= '0;
            in_b_q  <= '0;
            ctl_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            bub_q   <= '0;
        end else begin
            valid_q <= valid_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            ctl_q   <= ctl_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            bub_q   <= bub_d;
        end
    end

    assign bus.ex_valid       = valid_q;
    assign bus.ex_in_a        = in_a_q;
    assign bus.ex_in_b        = in_b_q;
    assign bus.ex_alu_control = ctl_q;
    assign bus.ex_rd_addr     = rd_q;
    assign bus.ex_reg_write   = rw_q;
    assign bus.ex_mem_read    = mr_q;
    assign bus.bubble_count   = 32'(bub_q);
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline register that directly feeds the ALU: it captures a decoded instruction, selects and forwards operands, and presents registered in_a/in_b/alu_control to the ALU.
It resolves distance-1 hazards (ALU result of the instruction it currently holds) and distance-2 hazards (MEM-stage result) by forwarding at capture time.
It inserts a one-cycle bubble on load-use hazards and honours downstream stall and flush.
It also keeps a saturating bubble counter for performance monitoring.

Parameters:
XLEN, 32, datapath width
REGW, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  decode stage offers an instruction
id_ready  output  1  stage accepts the instruction this cycle
id_pc  input  XLEN  instruction PC
id_rs1_addr, id_rs2_addr  input  REGW  source register addresses
id_rs1_data, id_rs2_data  input  XLEN  register-file read data (write-through for WB)
id_imm  input  XLEN  sign-extended immediate
id_a_sel  input  1  0 = rs1, 1 = PC
id_b_sel  input  1  0 = rs2, 1 = imm
id_alu_control  input  4  ALU opcode, passed through
id_rd_addr  input  REGW  destination register
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
alu_result  input  XLEN  combinational ALU output for the held instruction
mem_rd_addr  input  REGW  MEM-stage destination
mem_reg_write  input  1  MEM-stage writes rd
mem_fwd_data  input  XLEN  MEM-stage final result (load data or ALU result)
ex_ready  input  1  downstream accepts the held instruction
flush  input  1  kill held and incoming instruction (branch mispredict)
ex_valid  output  1  held instruction valid
ex_in_a, ex_in_b  output  XLEN  ALU operands
ex_alu_control  output  4  ALU opcode
ex_rd_addr  output  REGW  held destination
ex_reg_write, ex_mem_read  output  1  held control bits
bubble_count  output  32  number of load-use bubbles inserted, saturating

Behaviour:
- Reset: ex_valid=0, ex_in_a=0, ex_in_b=0, ex_alu_control=0, ex_rd_addr=0, ex_reg_write=0, ex_mem_read=0, bubble_count=0. id_ready=0 while rst is high.
- advance = ex_ready | ~ex_valid.
- hazard = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_rd_addr!=0) & ((~id_a_sel & id_rs1_addr==ex_rd_addr) | (~id_b_sel & id_rs2_addr==ex_rd_addr)).
- id_ready = advance & ~hazard & ~flush. This is combinational, with no dependency on id_valid.
- Per-operand forwarding (rsN value):
  - Priority 1, alu_result: when ex_valid & ex_reg_write & ~ex_mem_read & ex_rd_addr!=0 & ex_rd_addr==rsN_addr.
  - Priority 2, mem_fwd_data: when mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==rsN_addr.
  - Otherwise, id_rsN_data.
  - x0 is never forwarded.
- in_a = id_a_sel ? id_pc : rs1 value. in_b = id_b_sel ? id_imm : rs2 value.
- Next state, first matching rule:
  - flush → ex_valid=0 (data regs don't care; ex_reg_write, ex_mem_read forced 0).
  - ~advance → hold all registers.
  - hazard → ex_valid=0, ex_reg_write=0, ex_mem_read=0; bubble_count+1, saturating at 0xFFFFFFFF.
  - otherwise → ex_valid=id_valid, and all ex_* registers load from ID/select logic. With id_valid=0, control bits load 0.
- Latency: 1 cycle from ID handshake to ex_* valid. A load followed by a dependent instruction costs exactly 1 bubble. The dependent instruction then takes the load data from mem_fwd_data.
- While holding (~advance), registered operands stay frozen. The pipeline controller freezes MEM/WB in the same cycle, so no forwarded value is lost.
- flush and hazard in the same cycle: flush wins; bubble_count does not increment.
- flush with ex_ready=0: held instruction is killed anyway.
- rst mid-operation: all state returns to reset values on the next edge, including bubble_count.

Test Plan:
- Reset, then ID: addi x1 with a_sel=0, b_sel=1, rs1_data=5, imm=7, alu_control=0010 → next cycle ex_valid=1, ex_in_a=5, ex_in_b=7, ex_alu_control=0010.
- Held: rd=x3, reg_write=1, alu_result=0x10. ID: rs1=x3, rs1_data=0x99 → captured ex_in_a=0x10. Repeat with mem_rd_addr=x3, mem_fwd_data=0x20 also matching → still 0x10. Repeat with no EX match → 0x20.
- Held: load to x4. ID: rs2=x4, b_sel=0 → id_ready=0 one cycle, ex_valid=0 next cycle, bubble_count=1. Following cycle: mem_rd_addr=x4, mem_fwd_data=0xABCD → instruction captured with ex_in_b=0xABCD.
- rd=x0 matches with alu_result=0x55 and mem_fwd_data=0x66, rs1_data=0 → ex_in_a=0 captured.
- ex_valid=1, ex_ready=0 for 3 cycles with id_valid=1 → id_ready=0 and ex_* unchanged. Then ex_ready=1 → new instruction captured.
- flush together with a load-use hazard → ex_valid=0, bubble_count unchanged, id_ready=0. Preload bubble_count=0xFFFFFFFF and trigger a hazard → stays 0xFFFFFFFF.
